// File: rtl/brkpt_pkg.sv
// Shared constants and types for the KS10 bus breakpoint engine.
package brkpt_pkg;
  localparam logic [1:0] SEL_BRAR = 2'd0;
  localparam logic [1:0] SEL_BRMR = 2'd1;
  localparam logic [1:0] SEL_BRCR = 2'd2;
  localparam logic [1:0] SEL_BRPC = 2'd3;

  localparam int BRCR_EN = 4;

  localparam int TYPE_FETCH = 3;
  localparam int TYPE_READ  = 2;
  localparam int TYPE_WRITE = 1;
  localparam int TYPE_IO    = 0;

  typedef enum logic {
    ARMED   = 1'b0,
    TRIPPED = 1'b1
  } state_e;
endpackage

// File: rtl/brkpt_chan.sv
// One breakpoint channel: BRAR/BRMR/BRCR/BRPC, comparator and pass counter.
module brkpt_chan
  import brkpt_pkg::*;
#(
  parameter int ADDR_W = 36,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_armed,
  input  logic              i_bus_valid,
  input  logic [0:ADDR_W-1] i_bus_addr,
  input  logic [3:0]        i_bus_type,
  input  logic              i_wr,
  input  logic [1:0]        i_sel,
  input  logic [0:ADDR_W-1] i_data,
  output logic              o_qual
);
  logic [0:ADDR_W-1] r_brar;
  logic [0:ADDR_W-1] r_brmr;
  logic [4:0]        r_brcr;
  logic [CNT_W-1:0]  r_brpc;
  logic              w_match;
  logic              w_cnt_zero;

  assign w_match = i_bus_valid
                 && r_brcr[BRCR_EN]
                 && (((i_bus_addr ^ r_brar) & r_brmr) == '0)
                 && ((i_bus_type & r_brcr[3:0]) != 4'd0);

  assign w_cnt_zero = (r_brpc == '0);
  assign o_qual = i_armed && w_match && w_cnt_zero;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_brar <= '0;
      r_brmr <= '0;
      r_brcr <= '0;
      r_brpc <= '0;
    end else begin
      if (i_wr && i_sel == SEL_BRAR) r_brar <= i_data;
      if (i_wr && i_sel == SEL_BRMR) r_brmr <= i_data;
      if (i_wr && i_sel == SEL_BRCR)
        r_brcr <= i_data[ADDR_W-5:ADDR_W-1];
      // A console load of the count takes priority over a decrement.
      if (i_wr && i_sel == SEL_BRPC)
        r_brpc <= i_data[ADDR_W-CNT_W:ADDR_W-1];
      else if (i_armed && w_match && !w_cnt_zero)
        r_brpc <= r_brpc - 1'b1;
    end
  end
endmodule

// File: rtl/brkpt_unit.sv
// Breakpoint engine top: channel array, trip FSM, hit latch, priority encoder.
module brkpt_unit
  import brkpt_pkg::*;
#(
  parameter int NUM_BRK = 4,
  parameter int ADDR_W  = 36,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               busVALID,
  input  logic [0:ADDR_W-1]  busADDR,
  input  logic [3:0]         busTYPE,
  input  logic               regWR,
  input  logic [2:0]         regCHAN,
  input  logic [1:0]         regSEL,
  input  logic [0:ADDR_W-1]  regDATA,
  input  logic               haltACK,
  output logic               brkHALT,
  output logic [NUM_BRK-1:0] brkHIT,
  output logic [2:0]         brkCHAN
);
  state_e             r_state;
  logic [NUM_BRK-1:0] r_hit;
  logic [2:0]         r_chan;
  logic [NUM_BRK-1:0] w_qual;
  logic [2:0]         w_chan;
  logic               w_armed;

  assign w_armed = (r_state == ARMED);

  for (genvar g = 0; g < NUM_BRK; g++) begin : g_ch
    logic w_wr;
    assign w_wr = regWR && (regCHAN == 3'(g));
    brkpt_chan #(
      .ADDR_W(ADDR_W),
      .CNT_W (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .i_armed    (w_armed),
      .i_bus_valid(busVALID),
      .i_bus_addr (busADDR),
      .i_bus_type (busTYPE),
      .i_wr       (w_wr),
      .i_sel      (regSEL),
      .i_data     (regDATA),
      .o_qual     (w_qual[g])
    );
  end

  always_comb begin
    w_chan = 3'd0;
    for (int i = NUM_BRK - 1; i >= 0; i--)
      if (w_qual[i]) w_chan = 3'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ARMED;
      r_hit   <= '0;
      r_chan  <= 3'd0;
    end else begin
      unique case (r_state)
        ARMED: begin
          if (w_qual != '0) begin
            r_state <= TRIPPED;
            r_hit   <= w_qual;
            r_chan  <= w_chan;
          end
        end
        TRIPPED: begin
          if (haltACK) begin
            r_state <= ARMED;
            r_hit   <= '0;
          end
        end
        default: r_state <= ARMED;
      endcase
    end
  end

  assign brkHALT = (r_state == TRIPPED);
  assign brkHIT  = r_hit;
  assign brkCHAN = r_chan;
endmodule

// File: tb/tb_brkpt_unit.sv
// Directed-vector bench for brkpt_unit.
module tb_brkpt_unit;
  localparam int NB = 4;
  localparam int AW = 36;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          busVALID;
  logic [0:AW-1] busADDR;
  logic [3:0]    busTYPE;
  logic          regWR;
  logic [2:0]    regCHAN;
  logic [1:0]    regSEL;
  logic [0:AW-1] regDATA;
  logic          haltACK;
  logic          brkHALT;
  logic [NB-1:0] brkHIT;
  logic [2:0]    brkCHAN;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  brkpt_unit #(.NUM_BRK(NB), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .busVALID(busVALID), .busADDR(busADDR),
    .busTYPE(busTYPE), .regWR(regWR), .regCHAN(regCHAN),
    .regSEL(regSEL), .regDATA(regDATA), .haltACK(haltACK),
    .brkHALT(brkHALT), .brkHIT(brkHIT), .brkCHAN(brkCHAN)
  );

  typedef struct {
    logic          rst;
    logic          vld;
    logic [35:0]   addr;
    logic [3:0]    typ;
    logic          wr;
    logic [2:0]    ch;
    logic [1:0]    sel;
    logic [35:0]   data;
    logic          ack;
    logic          e_halt;
    logic [NB-1:0] e_hit;
    logic [2:0]    e_chan;
  } vec_t;

  vec_t vecs[$];

  localparam logic [3:0] TF = 4'b1000;
  localparam logic [3:0] TR = 4'b0100;
  localparam logic [3:0] TW = 4'b0010;
  localparam logic [35:0] ONES = 36'o777777777777;

  function automatic vec_t vr(input logic [2:0] ch, input logic [1:0] sel,
      input logic [35:0] d, input logic h, input logic [NB-1:0] hit,
      input logic [2:0] c);
    vec_t v;
    v = '{1'b0, 1'b0, 36'd0, 4'd0, 1'b1, ch, sel, d, 1'b0, h, hit, c};
    return v;
  endfunction

  function automatic vec_t vb(input logic [35:0] a, input logic [3:0] t,
      input logic ack, input logic h, input logic [NB-1:0] hit,
      input logic [2:0] c);
    vec_t v;
    v = '{1'b0, 1'b1, a, t, 1'b0, 3'd0, 2'd0, 36'd0, ack, h, hit, c};
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    rst = 0; busVALID = 0; busADDR = '0; busTYPE = 0;
    regWR = 0; regCHAN = 0; regSEL = 0; regDATA = '0; haltACK = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input vec_t v);
    rst = v.rst; busVALID = v.vld; busADDR = v.addr; busTYPE = v.typ;
    regWR = v.wr; regCHAN = v.ch; regSEL = v.sel; regDATA = v.data;
    haltACK = v.ack;
    tick();
    idle();
  endtask

  task automatic wreg(input logic [2:0] ch, input logic [1:0] sel,
                      input logic [35:0] d);
    apply(vr(ch, sel, d, brkHALT, brkHIT, brkCHAN));
  endtask

  task automatic bus(input logic [35:0] a, input logic [3:0] t);
    busVALID = 1; busADDR = a; busTYPE = t;
    tick();
    idle();
  endtask

  initial begin
    vec_t v;
    idle();
    v = vb(36'd0, 4'd0, 1'b0, 1'b0, 4'b0000, 3'd0);
    v.rst = 1'b1; v.vld = 1'b0;
    vecs.push_back(v);
    vecs.push_back(vr(0, 0, 36'o1000, 0, 4'b0000, 0));
    vecs.push_back(vr(0, 1, ONES, 0, 4'b0000, 0));
    vecs.push_back(vr(0, 2, 36'h14, 0, 4'b0000, 0));
    vecs.push_back(vb(36'o1000, TW, 0, 0, 4'b0000, 0));
    vecs.push_back(vb(36'o1000, TR, 0, 1, 4'b0001, 0));
    v = vb(36'd0, 4'd0, 1'b1, 1'b0, 4'b0000, 3'd0);
    v.vld = 1'b0;
    vecs.push_back(v);
    vecs.push_back(vr(0, 2, 36'h0, 0, 4'b0000, 0));
    vecs.push_back(vr(1, 0, 36'o1000, 0, 4'b0000, 0));
    vecs.push_back(vr(1, 1, 36'o777777777000, 0, 4'b0000, 0));
    vecs.push_back(vr(1, 2, 36'h1F, 0, 4'b0000, 0));
    vecs.push_back(vb(36'o2000, TR, 0, 0, 4'b0000, 0));
    vecs.push_back(vb(36'o1777, TR, 0, 1, 4'b0010, 1));
    vecs.push_back(vb(36'o5000, TW, 1, 0, 4'b0000, 1));
    vecs.push_back(vr(3, 2, 36'h14, 0, 4'b0000, 1));
    vecs.push_back(vr(5, 2, 36'h1F, 0, 4'b0000, 1));
    vecs.push_back(vb(36'o1500, TR, 0, 1, 4'b1010, 1));
    vecs.push_back(vb(36'o1500, TR, 0, 1, 4'b1010, 1));
    vecs.push_back(vb(36'o1500, TR, 1, 0, 4'b0000, 1));
    vecs.push_back(vb(36'o7000, TF, 0, 0, 4'b0000, 1));
    vecs.push_back(vr(1, 2, 36'h0, 0, 4'b0000, 1));
    vecs.push_back(vr(3, 2, 36'h0, 0, 4'b0000, 1));
    vecs.push_back(vb(36'o1500, TR, 0, 0, 4'b0000, 1));

    foreach (vecs[i]) begin
      apply(vecs[i]);
      chk($sformatf("v%0d.halt", i), 64'(brkHALT), 64'(vecs[i].e_halt));
      chk($sformatf("v%0d.hit", i), 64'(brkHIT), 64'(vecs[i].e_hit));
      chk($sformatf("v%0d.chan", i), 64'(brkCHAN), 64'(vecs[i].e_chan));
    end

    wreg(2, 0, 36'o400);
    wreg(2, 1, ONES);
    wreg(2, 2, 36'h18);
    wreg(2, 3, 36'd3);
    chk("pc.load", 64'(dut.g_ch[2].u_chan.r_brpc), 64'd3);
    for (int k = 0; k < 3; k++) begin
      bus(36'o400, TF);
      chk($sformatf("pc.skip%0d", k), 64'(brkHALT), 64'd0);
      chk($sformatf("pc.cnt%0d", k),
          64'(dut.g_ch[2].u_chan.r_brpc), 64'(2 - k));
    end
    bus(36'o400, TF);
    chk("pc.trip", 64'(brkHALT), 64'd1);
    chk("pc.hit", 64'(brkHIT), 64'b0100);
    chk("pc.chan", 64'(brkCHAN), 64'd2);
    bus(36'o400, TF);
    chk("pc.frozen", 64'(dut.g_ch[2].u_chan.r_brpc), 64'd0);
    chk("pc.hold", 64'(brkHALT), 64'd1);
    haltACK = 1;
    tick();
    idle();
    chk("pc.ack", 64'(brkHALT), 64'd0);

    wreg(2, 3, 36'd2);
    busVALID = 1; busADDR = 36'o400; busTYPE = TF;
    regWR = 1; regCHAN = 2; regSEL = 2'd3; regDATA = 36'd5;
    tick();
    idle();
    chk("coll.pc", 64'(dut.g_ch[2].u_chan.r_brpc), 64'd5);
    chk("coll.halt", 64'(brkHALT), 64'd0);

    wreg(2, 3, 36'd7);
    wreg(2, 2, 36'h08);
    chk("dis.pc", 64'(dut.g_ch[2].u_chan.r_brpc), 64'd7);
    wreg(2, 3, 36'd0);
    wreg(2, 2, 36'h18);
    bus(36'o400, TF);
    chk("rst.pre", 64'(brkHALT), 64'd1);
    rst = 1;
    busVALID = 1; busADDR = 36'o400; busTYPE = TF;
    tick();
    idle();
    chk("rst.halt", 64'(brkHALT), 64'd0);
    chk("rst.hit", 64'(brkHIT), 64'd0);
    chk("rst.chan", 64'(brkCHAN), 64'd0);
    chk("rst.brar", 64'(dut.g_ch[2].u_chan.r_brar), 64'd0);
    chk("rst.brmr", 64'(dut.g_ch[1].u_chan.r_brmr), 64'd0);
    chk("rst.brcr", 64'(dut.g_ch[2].u_chan.r_brcr), 64'd0);
    bus(36'o400, TF);
    bus(36'o1000, TR);
    bus(36'o0, TR | TW | TF);
    chk("rst.nohalt", 64'(brkHALT), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
